reg_write_arbiter: RTL and testbench

//  Shares the single write port of the 8 x 4-bit register bank between two writers (port A: ALU

---
 rtl/regbank_pkg.sv | 27 ++
 rtl/rb_req_buffer.sv | 63 ++++++
 rtl/reg_write_arbiter.sv | 132 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the register-bank write path.
package regbank_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int REG_DATA_W = 4;
   localparam int NUM_REGS   = 8;

   localparam logic [REG_ADDR_W-1:0] REG_NONE = 3'd0;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // One-hot decode of a register select; R0 is the "no write" select and never marks busy.
   function automatic logic [NUM_REGS-1:0] reg_decode(input logic                  en,
                                                     input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] m;
      m = {NUM_REGS{1'b0}};
      if (en) begin
         m[addr] = 1'b1;
      end else begin
         m = {NUM_REGS{1'b0}};
      end
      m[0] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/rb_req_buffer.sv
// One-entry holding register with valid/ready handshake on the input and a pop on the output.
module rb_req_buffer
   import regbank_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_valid_i,
   output logic              ready_o,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   // Next-state: a held entry leaves only on pop; an empty buffer loads on a valid request.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (valid_q) begin
         if (pop_i) begin
            valid_d = 1'b0;
         end else begin
            valid_d = 1'b1;
         end
      end else if (push_valid_i) begin
         valid_d = 1'b1;
         addr_d  = addr_i;
         data_d  = data_i;
      end else begin
         valid_d = 1'b0;
      end
   end

   // Entry storage; reset empties the buffer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         data_q  <= {DATA_W{1'b0}};
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Ready depends only on stored state, so there is no valid->ready combinational path.
   assign ready_o = ~valid_q;
   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-bank write port between two buffered writers.
module reg_write_arbiter
   import regbank_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W,
   parameter int COLL_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic [ADDR_W-1:0] Reg_En,
   output logic [DATA_W-1:0] ValStore,
   output logic [7:0]        busy_mask,
   output logic [COLL_W-1:0] coll_count
);

   logic              buf_a_v_s, buf_b_v_s;
   logic [ADDR_W-1:0] buf_a_addr_s, buf_b_addr_s;
   logic [DATA_W-1:0] buf_a_data_s, buf_b_data_s;
   logic              grant_a_s, grant_b_s;

   logic              ptr_q, ptr_d;
   logic [ADDR_W-1:0] en_q, en_d;
   logic [DATA_W-1:0] val_q, val_d;
   logic [COLL_W-1:0] coll_q, coll_d;

   rb_req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_a (
      .clk_i        (Clk),
      .rst_i        (Reset),
      .push_valid_i (a_valid),
      .ready_o      (a_ready),
      .addr_i       (a_addr),
      .data_i       (a_data),
      .pop_i        (grant_a_s),
      .valid_o      (buf_a_v_s),
      .addr_o       (buf_a_addr_s),
      .data_o       (buf_a_data_s)
   );

   rb_req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_b (
      .clk_i        (Clk),
      .rst_i        (Reset),
      .push_valid_i (b_valid),
      .ready_o      (b_ready),
      .addr_i       (b_addr),
      .data_i       (b_data),
      .pop_i        (grant_b_s),
      .valid_o      (buf_b_v_s),
      .addr_o       (buf_b_addr_s),
      .data_o       (buf_b_data_s)
   );

   // Grant selection: a lone requester wins; under contention the pointer decides and then flips.
   always_comb begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      ptr_d     = ptr_q;
      case ({buf_a_v_s, buf_b_v_s})
         2'b10: grant_a_s = 1'b1;
         2'b01: grant_b_s = 1'b1;
         2'b11: begin
            if (ptr_q == PORT_A) begin
               grant_a_s = 1'b1;
            end else begin
               grant_b_s = 1'b1;
            end
            ptr_d = ~ptr_q;
         end
         default: begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
         end
      endcase
   end

   // Output-stage and contention-counter next state.
   always_comb begin
      en_d   = {ADDR_W{1'b0}};
      val_d  = {DATA_W{1'b0}};
      coll_d = coll_q;
      if (grant_a_s) begin
         en_d  = buf_a_addr_s;
         val_d = buf_a_data_s;
      end else if (grant_b_s) begin
         en_d  = buf_b_addr_s;
         val_d = buf_b_data_s;
      end else begin
         en_d  = REG_NONE;
         val_d = {DATA_W{1'b0}};
      end
      if (buf_a_v_s && buf_b_v_s && (coll_q != {COLL_W{1'b1}})) begin
         coll_d = coll_q + {{(COLL_W-1){1'b0}}, 1'b1};
      end else begin
         coll_d = coll_q;
      end
   end

   // State registers: pointer, registered bank write port, contention counter.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ptr_q  <= PORT_A;
         en_q   <= {ADDR_W{1'b0}};
         val_q  <= {DATA_W{1'b0}};
         coll_q <= {COLL_W{1'b0}};
      end else begin
         ptr_q  <= ptr_d;
         en_q   <= en_d;
         val_q  <= val_d;
         coll_q <= coll_d;
      end
   end

   // Busy decode is built purely from stored state: both buffers plus the write in the output stage.
   always_comb begin
      busy_mask = reg_decode(buf_a_v_s, buf_a_addr_s)
                | reg_decode(buf_b_v_s, buf_b_addr_s)
                | reg_decode(1'b1, en_q);
   end

   assign Reg_En     = en_q;
   assign ValStore   = val_q;
   assign coll_count = coll_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomised and directed bench for reg_write_arbiter against a transaction-level model.
module tb_reg_write_arbiter;
   import regbank_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       a_valid, b_valid;
   logic       a_ready, b_ready;
   logic [2:0] a_addr, b_addr;
   logic [3:0] a_data, b_data;
   logic [2:0] Reg_En;
   logic [3:0] ValStore;
   logic [7:0] busy_mask;
   logic [7:0] coll_count;

   reg_write_arbiter dut (
      .Clk(Clk), .Reset(Reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .Reg_En(Reg_En), .ValStore(ValStore), .busy_mask(busy_mask), .coll_count(coll_count)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: each port holds at most one pending write; one write leaves per cycle.
   bit         ma_v, mb_v;
   logic [2:0] ma_addr, mb_addr;
   logic [3:0] ma_data, mb_data;
   bit         m_turn_b;
   logic [2:0] m_en;
   logic [3:0] m_val;
   int         m_coll;
   logic [3:0] m_bank [8];
   logic [3:0] d_bank [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      ma_v = 0; mb_v = 0; m_turn_b = 0;
      m_en = 3'd0; m_val = 4'd0; m_coll = 0;
   endfunction

   function automatic logic [7:0] model_busy();
      logic [7:0] m;
      m = 8'h00;
      for (int r = 1; r < 8; r++) begin
         if ((ma_v && ma_addr == r) || (mb_v && mb_addr == r) || (m_en == r)) m[r] = 1'b1;
      end
      return m;
   endfunction

   task automatic model_step();
      bit acc_a, acc_b;
      int win;
      if (Reset) begin
         model_reset();
      end else begin
         acc_a = a_valid && !ma_v;
         acc_b = b_valid && !mb_v;
         win = -1;
         if (ma_v && mb_v) begin
            win = m_turn_b ? 1 : 0;
            m_turn_b = !m_turn_b;
            if (m_coll < 255) m_coll++;
         end else if (ma_v) win = 0;
         else if (mb_v) win = 1;
         if (win == 0) begin
            m_en = ma_addr; m_val = ma_data; ma_v = 0;
         end else if (win == 1) begin
            m_en = mb_addr; m_val = mb_data; mb_v = 0;
         end else begin
            m_en = 3'd0; m_val = 4'd0;
         end
         if (m_en != 3'd0) m_bank[m_en] = m_val;
         if (acc_a) begin ma_v = 1; ma_addr = a_addr; ma_data = a_data; end
         if (acc_b) begin mb_v = 1; mb_addr = b_addr; mb_data = b_data; end
      end
   endtask

   // One clock: model advances on the rising edge, outputs are compared on the falling edge.
   task automatic tick();
      @(posedge Clk);
      model_step();
      @(negedge Clk);
      chk("a_ready", a_ready, !ma_v);
      chk("b_ready", b_ready, !mb_v);
      chk("Reg_En", Reg_En, m_en);
      chk("ValStore", ValStore, m_val);
      chk("busy_mask", busy_mask, model_busy());
      chk("coll_count", coll_count, m_coll);
      if (Reg_En != 3'd0) d_bank[Reg_En] = ValStore;
   endtask

   task automatic drive(input bit av, input int aa, input int ad,
                        input bit bv, input int ba, input int bd);
      a_valid = av; a_addr = aa[2:0]; a_data = ad[3:0];
      b_valid = bv; b_addr = ba[2:0]; b_data = bd[3:0];
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset pulse in the middle of a cycle; outputs must clear without a clock edge.
   task automatic pulse_reset();
      #2 Reset = 1'b1;
      model_reset();
      #1;
      chk("rst_a_ready", a_ready, 1);
      chk("rst_b_ready", b_ready, 1);
      chk("rst_Reg_En", Reg_En, 0);
      chk("rst_ValStore", ValStore, 0);
      chk("rst_busy", busy_mask, 0);
      chk("rst_coll", coll_count, 0);
      idle();
      tick();
      #2 Reset = 1'b0;
   endtask

   initial begin
      for (int r = 0; r < 8; r++) begin m_bank[r] = 4'd0; d_bank[r] = 4'd0; end
      Reset = 1'b1;
      idle();
      model_reset();
      tick();
      tick();
      #2 Reset = 1'b0;

      // A only: R3 <= 9
      drive(1, 3, 9, 0, 0, 0);
      tick();
      idle();
      chk("a_only_ready_low", a_ready, 0);
      chk("a_only_busy_n", busy_mask, 8'h08);
      chk("a_only_en_n", Reg_En, 0);
      tick();
      chk("a_only_en", Reg_En, 3);
      chk("a_only_val", ValStore, 9);
      chk("a_only_busy_n1", busy_mask, 8'h08);
      chk("a_only_ready_back", a_ready, 1);
      tick();
      chk("a_only_en_clear", Reg_En, 0);
      chk("a_only_busy_clear", busy_mask, 8'h00);

      // Contention: A(R2,5) B(R5,C), pointer starts at A
      drive(1, 2, 5, 1, 5, 12);
      tick();
      idle();
      chk("cont_busy", busy_mask, 8'h24);
      chk("cont_coll0", coll_count, 0);
      tick();
      chk("cont_first_en", Reg_En, 2);
      chk("cont_first_val", ValStore, 5);
      chk("cont_coll1", coll_count, 1);
      tick();
      chk("cont_second_en", Reg_En, 5);
      chk("cont_second_val", ValStore, 12);
      drive(1, 1, 1, 1, 6, 6);
      tick();
      idle();
      tick();
      chk("cont2_b_first", Reg_En, 6);
      chk("cont2_coll", coll_count, 2);
      tick();
      chk("cont2_a_second", Reg_En, 1);
      tick();

      // Same destination: R4 <= 1 then R4 <= 7
      drive(1, 4, 1, 1, 4, 7);
      tick();
      idle();
      chk("same_busy0", busy_mask, 8'h10);
      tick();
      chk("same_first", {Reg_En, ValStore}, {3'd4, 4'd1});
      chk("same_busy1", busy_mask, 8'h10);
      tick();
      chk("same_second", {Reg_En, ValStore}, {3'd4, 4'd7});
      chk("same_busy2", busy_mask, 8'h10);
      tick();
      chk("same_busy_clear", busy_mask, 8'h00);
      chk("same_final", d_bank[4], 7);

      // R0 write through port B
      drive(0, 0, 0, 1, 0, 15);
      tick();
      idle();
      chk("r0_ready_low", b_ready, 0);
      chk("r0_busy", busy_mask, 8'h00);
      tick();
      chk("r0_ready_back", b_ready, 1);
      chk("r0_en", Reg_En, 0);
      chk("r0_val", ValStore, 15);
      chk("r0_busy2", busy_mask, 8'h00);
      tick();

      // Reset mid-operation with a write in flight
      drive(1, 6, 3, 0, 0, 0);
      tick();
      idle();
      pulse_reset();

      // Reset during contention drops both writes and the pointer returns to A
      drive(1, 3, 3, 1, 5, 5);
      tick();
      tick();
      idle();
      pulse_reset();
      tick();
      chk("rst6_no_write0", Reg_En, 0);
      tick();
      chk("rst6_no_write1", Reg_En, 0);
      chk("rst6_coll", coll_count, 0);
      drive(1, 1, 2, 1, 2, 3);
      tick();
      idle();
      tick();
      chk("rst6_ptr_a", Reg_En, 1);
      tick();
      tick();

      // Random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         a_valid = ($urandom_range(0, 2) != 0);
         b_valid = ($urandom_range(0, 2) != 0);
         a_addr = 3'($urandom_range(0, 7)); a_data = 4'($urandom_range(0, 15));
         b_addr = 3'($urandom_range(0, 7)); b_data = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) pulse_reset();
         else tick();
      end
      idle();
      tick();
      tick();

      // Saturation: force repeated simultaneous accepts
      pulse_reset();
      for (int i = 0; i < 900; i++) begin
         if (!ma_v && !mb_v) begin
            drive(1, $urandom_range(0, 7), $urandom_range(0, 15),
                  1, $urandom_range(0, 7), $urandom_range(0, 15));
         end else begin
            idle();
         end
         tick();
      end
      idle();
      tick();
      tick();
      chk("sat_model", m_coll, 255);
      chk("sat_coll", coll_count, 8'hFF);

      for (int r = 1; r < 8; r++) chk("bank", d_bank[r], m_bank[r]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
